joy_serial_scan: RTL and testbench

Scanner for the serial joystick port on the UnAmiga board. It drives the clock and load lines of the on-board 74HC165 shift-register chain and shifts in 16 bits per scan. It then produces debounced, active-low 8-bit joystick words `joy1`/`joy2`, which feed the controller's joystick inputs. All outputs are registered, and the block runs entirely in the controller's clock domain.

---
 rtl/joy_serial_scan.sv | 146 ++++++++++++++
 tb/tb_joy_serial_scan.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/joy_serial_scan.sv
// joy_serial_scan: drives a 74HC165 joystick chain and produces registered active-low pad words.
// Define JOY_DEBOUNCE_EN to add per-button scan-count debouncing.
module joy_serial_scan #(
    parameter int CLK_DIV        = 16,
    parameter int SCAN_GAP       = 1024,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       joy_clk,
    output logic       joy_load,
    input  logic       joy_data,
    output logic       joy_p7,
    output logic [7:0] joy1,
    output logic [7:0] joy2,
    output logic       scan_done
);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int GW = $clog2(SCAN_GAP + 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    if (CLK_DIV < 1 || SCAN_GAP < 1 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_param_check
        $error("joy_serial_scan: parameter out of range");
    end

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [3:0]    bit_q, bit_d;
    logic          phase_q, phase_d;
    logic [11:0]   sr_q, sr_d;
    logic [11:0]   btn_q, btn_d;
    logic          clk_q, load_q, done_q;
    logic          div_end;
    logic [11:0]   raw;

    assign div_end = div_q == DW'(CLK_DIV - 1);
    // Only the six button bits of each pad are kept; bits 0,1,8,9 of the stream are the unused pad bits.
    assign raw = sr_q;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        gap_d   = gap_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        sr_d    = sr_q;
        case (state_q)
            IDLE: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GW'(SCAN_GAP - 1)) begin
                    state_d = LOAD;
                    gap_d   = '0;
                    div_d   = '0;
                end
            end
            LOAD: begin
                div_d = div_q + 1'b1;
                if (div_end) begin
                    state_d = SHIFT;
                    div_d   = '0;
                    bit_d   = '0;
                    phase_d = 1'b0;
                end
            end
            SHIFT: begin
                div_d = div_q + 1'b1;
                if (div_end) begin
                    div_d   = '0;
                    phase_d = ~phase_q;
                    if (!phase_q) begin
                        sr_d = (|bit_q[2:1]) ? {sr_q[10:0], joy_data} : sr_q;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        if (bit_q == 4'd15) state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef JOY_DEBOUNCE_EN
    logic [11:0][3:0] cnt_q, cnt_d;

    always_comb begin
        btn_d = btn_q;
        cnt_d = cnt_q;
        if (state_q == DONE) begin
            for (int i = 0; i < 12; i++) begin
                if (raw[i] == btn_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] + 4'd1 == 4'(DEBOUNCE_SCANS)) begin
                    btn_d[i] = raw[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`else
    assign btn_d = (state_q == DONE) ? raw : btn_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            gap_q   <= '0;
            bit_q   <= '0;
            phase_q <= 1'b0;
            sr_q    <= '1;
            btn_q   <= '1;
            clk_q   <= 1'b0;
            load_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            gap_q   <= gap_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            sr_q    <= sr_d;
            btn_q   <= btn_d;
            clk_q   <= (state_d == SHIFT) && phase_d;
            load_q  <= state_d != LOAD;
            done_q  <= state_q == DONE;
        end
    end

    assign joy_clk   = clk_q;
    assign joy_load  = load_q;
    assign scan_done = done_q;
    assign joy_p7    = 1'b1;
    assign joy1      = {2'b11, btn_q[11:6]};
    assign joy2      = {2'b11, btn_q[5:0]};
endmodule

// File: tb/tb_joy_serial_scan.sv
// tb_joy_serial_scan: random/directed scans of a modelled '165 chain checked against a pad-level reference.
module tb_joy_serial_scan;
    localparam int CLK_DIV  = 16;
    localparam int SCAN_GAP = 1024;
    localparam int DEB      = 3;
    localparam int PERIOD   = CLK_DIV + 32 * CLK_DIV + 1 + SCAN_GAP;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        joy_data, joy_clk, joy_load, joy_p7, scan_done;
    logic [7:0]  joy1, joy2;
    logic [15:0] pat_drive = 16'hFFFF;
    logic [15:0] chain = 16'hFFFF;
    logic        jc_q = 1'b0;

    int n_chk = 0, n_pass = 0;
    int cyc, load_len, pulses, hi_run, lo_run, width_err, overlap, chg_err;
    logic in_scan, clk_prev, have_prev;
    logic [7:0] j1_prev, j2_prev;
    logic [11:0] out_m;
    int cnt_m[12];

    joy_serial_scan #(.CLK_DIV(CLK_DIV), .SCAN_GAP(SCAN_GAP), .DEBOUNCE_SCANS(DEB)) dut (
        .clk(clk), .reset_n(reset_n), .joy_clk(joy_clk), .joy_load(joy_load), .joy_data(joy_data),
        .joy_p7(joy_p7), .joy1(joy1), .joy2(joy2), .scan_done(scan_done)
    );

    always #5 clk = ~clk;

    // '165 chain: parallel load while load is low, shift on a joy_clk rising edge, MSB out
    assign joy_data = chain[15];
    always @(posedge clk) begin
        if (!joy_load) chain <= pat_drive;
        else if (joy_clk && !jc_q) chain <= {chain[14:0], 1'b1};
        jc_q <= joy_clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        out_m = '1;
        for (int i = 0; i < 12; i++) cnt_m[i] = 0;
    endtask

    task automatic model_scan(input logic [15:0] p);
        logic [11:0] r;
        r = {p[13:8], p[5:0]};
`ifdef JOY_DEBOUNCE_EN
        for (int i = 0; i < 12; i++) begin
            if (r[i] == out_m[i]) cnt_m[i] = 0;
            else begin
                cnt_m[i]++;
                if (cnt_m[i] == DEB) begin
                    out_m[i] = r[i];
                    cnt_m[i] = 0;
                end
            end
        end
`else
        out_m = r;
`endif
    endtask

    task automatic clear_stats();
        load_len = 0; pulses = 0; hi_run = 0; lo_run = 0;
        width_err = 0; overlap = 0; chg_err = 0; in_scan = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (!joy_load) begin load_len++; in_scan = 1'b1; lo_run = 0; end
        if (!joy_load && joy_clk) overlap++;
        if (joy_clk) begin
            if (!clk_prev && lo_run != CLK_DIV) width_err++;
            hi_run++;
        end else begin
            if (clk_prev) begin
                pulses++;
                if (hi_run != CLK_DIV) width_err++;
                hi_run = 0;
                lo_run = 0;
            end
            if (joy_load && in_scan) lo_run++;
        end
        if (!scan_done && (joy1 !== j1_prev || joy2 !== j2_prev)) chg_err++;
        clk_prev = joy_clk; j1_prev = joy1; j2_prev = joy2;
    endtask

    task automatic first_load();
        int n = 0;
        logic seen = 1'b0;
        while (!seen && n < 2 * SCAN_GAP) begin
            @(posedge clk); n++;
            #1 seen = !joy_load;
        end
        check("first_load_edge", n, SCAN_GAP);
        check("idle_joy1", joy1, 8'hFF);
    endtask

    task automatic do_scan(input logic [15:0] p);
        logic seen = 1'b0;
        pat_drive = p;
        for (int n = 0; n < 2 * PERIOD && !seen; n++) begin
            tick();
            seen = scan_done;
        end
        check("scan_seen", seen, 1'b1);
        if (!seen) return;
        model_scan(p);
        check("joy1", joy1, {2'b11, out_m[11:6]});
        check("joy2", joy2, {2'b11, out_m[5:0]});
        check("load_len", load_len, CLK_DIV);
        check("clk_pulses", pulses, 16);
        check("clk_width_err", width_err, 0);
        check("load_clk_overlap", overlap, 0);
        check("out_change_off_done", chg_err, 0);
        check("joy_p7", joy_p7, 1'b1);
        if (have_prev) check("scan_period", cyc, PERIOD);
        cyc = 0; have_prev = 1'b1;
        clear_stats();
        tick();
        check("done_width", scan_done, 1'b0);
    endtask

    initial begin
        logic [15:0] rp;
        int n, dn;
        model_reset(); clear_stats();
        cyc = 0; have_prev = 1'b0; clk_prev = 1'b0;
        #1 reset_n = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_joy1", joy1, 8'hFF);
        check("rst_joy2", joy2, 8'hFF);
        check("rst_done", scan_done, 1'b0);
        check("rst_joy_clk", joy_clk, 1'b0);
        check("rst_joy_load", joy_load, 1'b1);
        check("rst_joy_p7", joy_p7, 1'b1);
        pat_drive = 16'hFEDF;
        reset_n = 1'b1;
        j1_prev = joy1; j2_prev = joy2;
        first_load();
        foreach (rp[i]) rp[i] = 1'b1;
        begin
            logic [15:0] seq [18] = '{16'hFEDF, 16'hFEDF, 16'hFEDF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                                     16'hF7FF, 16'hF7FF, 16'hF7FF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                                     16'hF7FF, 16'hF7FF, 16'hFFFF, 16'hF7FF, 16'hF7FF, 16'hFFFF};
            foreach (seq[i]) do_scan(seq[i]);
        end
        for (int s = 0; s < 8; s++) begin
            if (s == 0 || $urandom_range(0, 2) == 0) rp = 16'($urandom);
            do_scan(rp);
        end
        repeat (3) do_scan(16'h0000);
        pat_drive = 16'h0000;
        n = 0;
        while (!(pulses == 7 && joy_clk) && n < 3 * PERIOD) begin tick(); n++; end
        check("reach_bit7", pulses, 7);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_joy_clk", joy_clk, 1'b0);
        check("mid_rst_joy_load", joy_load, 1'b1);
        check("mid_rst_joy1", joy1, 8'hFF);
        check("mid_rst_joy2", joy2, 8'hFF);
        dn = 0;
        repeat (5) begin @(negedge clk); dn += int'(scan_done); end
        check("mid_rst_no_done", dn, 0);
        model_reset(); clear_stats();
        have_prev = 1'b0; cyc = 0; clk_prev = 1'b0;
        reset_n = 1'b1;
        j1_prev = joy1; j2_prev = joy2;
        first_load();
        repeat (3) do_scan(16'h0000);
        do_scan(16'hFFFF);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
